// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning the architectural HI/LO registers.
//
// A mult/multu/div/divu is accepted only when idle and not flushed by Req. The 64-bit result
// is computed from the operands sampled at the accept edge, held internally, and written to
// HI/LO on the edge where the busy counter reaches zero. mthi/mtlo write directly with no
// busy cycles. An operation already in flight always completes, regardless of Req.
// Both cycle parameters must be at least 1.
//
// Ports:
//   clk      - clock, rising-edge active
//   reset    - asynchronous active-low reset
//   Req      - exception/interrupt flush; blocks acceptance of md_op this cycle
//   md_op    - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   rs_data  - operand A (dividend, mthi/mtlo source)
//   rt_data  - operand B (divisor)
//   rd_sel   - md_out select: 0 HI, 1 LO
//   busy     - operation in flight
//   hi, lo   - architectural HI/LO registers
//   md_out   - rd_sel ? lo : hi
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = (MaxCycles == 0) ? 1 : $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } md_op_e;

    md_op_e op;
    assign op = md_op_e'(md_op);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     hi_q, hi_d;
    logic [31:0]     lo_q, lo_d;
    logic [63:0]     res_q, res_d;
    logic            res_wr_q, res_wr_d;   // cleared on divide-by-zero: HI/LO left untouched

    // Arithmetic datapath
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic               div_zero;
    logic               div_neg1;
    logic signed [31:0] div_b_s;
    logic signed [31:0] quo_s, rem_s;
    logic        [31:0] div_b_u;
    logic        [31:0] quo_u, rem_u;

    assign prod_s   = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u   = {32'b0, rs_data} * {32'b0, rt_data};
    assign div_zero = (rt_data == 32'h0);
    assign div_neg1 = (rt_data == 32'hFFFF_FFFF);

    // Divisor -1 is resolved by negation so 0x80000000 / -1 wraps to 0x80000000 instead of
    // overflowing the divider; zero divisors are replaced to keep the divider well defined.
    assign div_b_s  = (div_zero || div_neg1) ? 32'sd1 : $signed(rt_data);
    assign div_b_u  = div_zero ? 32'd1 : rt_data;

    always_comb begin
        quo_s = $signed(rs_data) / div_b_s;
        rem_s = $signed(rs_data) % div_b_s;
        if (div_neg1) begin
            quo_s = $signed(32'd0 - rs_data);
            rem_s = 32'sd0;
        end
    end

    assign quo_u = rs_data / div_b_u;
    assign rem_u = rs_data % div_b_u;

    // Next-state logic
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_d    = res_q;
        res_wr_d = res_wr_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CntW'(1) && res_wr_q) begin
                hi_d = res_q[63:32];
                lo_d = res_q[31:0];
            end
        end else if (!Req) begin
            unique case (op)
                OpMult: begin
                    res_d    = prod_s;
                    res_wr_d = 1'b1;
                    cnt_d    = CntW'(MULT_CYCLES);
                end
                OpMultu: begin
                    res_d    = prod_u;
                    res_wr_d = 1'b1;
                    cnt_d    = CntW'(MULT_CYCLES);
                end
                OpDiv: begin
                    res_d    = {rem_s, quo_s};
                    res_wr_d = !div_zero;
                    cnt_d    = CntW'(DIV_CYCLES);
                end
                OpDivu: begin
                    res_d    = {rem_u, quo_u};
                    res_wr_d = !div_zero;
                    cnt_d    = CntW'(DIV_CYCLES);
                end
                OpMthi:  hi_d = rs_data;
                OpMtlo:  lo_d = rs_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            res_q    <= '0;
            res_wr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_q    <= res_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign busy   = (cnt_q != '0);
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign md_out = rd_sel ? lo_q : hi_q;

endmodule

// File: tb/tb_md_unit.sv
module tb_md_unit;

    localparam int MultCycles = 5;
    localparam int DivCycles  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        Req;
    logic [2:0]  md_op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_sel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    always #5 clk = ~clk;

    md_unit #(
        .MULT_CYCLES(MultCycles),
        .DIV_CYCLES (DivCycles)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .Req    (Req),
        .md_op  (md_op),
        .rs_data(rs_data),
        .rt_data(rt_data),
        .rd_sel (rd_sel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: architectural HI/LO plus one pending result that lands after its
    // busy window. busy_until is the last cycle number in which the unit reads busy.
    longint      cyc        = 0;
    longint      busy_until = -1;
    bit          pend       = 1'b0;
    bit          pend_wr    = 1'b0;
    logic [31:0] pend_hi    = '0;
    logic [31:0] pend_lo    = '0;
    logic [31:0] m_hi       = '0;
    logic [31:0] m_lo       = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%08h exp=%08h", tag, cyc, got, exp);
        end
    endtask

    function automatic void ref_calc(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output bit wr,
                                     output logic [31:0] h, output logic [31:0] l);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        wr = 1'b1;
        h  = '0;
        l  = '0;
        case (op)
            3'd1: begin p = sa * sb; h = p[63:32]; l = p[31:0]; end
            3'd2: begin p = ua * ub; h = p[63:32]; l = p[31:0]; end
            3'd3: begin
                if (b == 32'h0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
            end
            3'd4: begin
                if (b == 32'h0) wr = 1'b0;
                else begin p = ua / ub; l = p[31:0]; p = ua % ub; h = p[31:0]; end
            end
            default: wr = 1'b0;
        endcase
    endfunction

    // One clock cycle: drive inputs, compare outputs against the model, update the model
    // for an accepted op, then advance to 1 time unit after the next rising edge.
    task automatic cycle(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit req, input bit sel);
        bit          m_busy;
        bit          wr;
        logic [31:0] h, l;
        md_op   = op;
        rs_data = a;
        rt_data = b;
        Req     = req;
        rd_sel  = sel;
        if (pend && cyc > busy_until) begin
            if (pend_wr) begin
                m_hi = pend_hi;
                m_lo = pend_lo;
            end
            pend = 1'b0;
        end
        m_busy = (cyc <= busy_until);
        #1;
        check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
        check_eq("hi", hi, m_hi);
        check_eq("lo", lo, m_lo);
        check_eq("md_out", md_out, sel ? m_lo : m_hi);
        if (!m_busy && !req && op >= 3'd1 && op <= 3'd6) begin
            if (op == 3'd5) m_hi = a;
            else if (op == 3'd6) m_lo = a;
            else begin
                ref_calc(op, a, b, wr, h, l);
                pend       = 1'b1;
                pend_wr    = wr;
                pend_hi    = h;
                pend_lo    = l;
                busy_until = cyc + ((op <= 3'd2) ? MultCycles : DivCycles);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Idle until busy drops, bounded; returns the number of busy cycles seen.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            cycle(3'd0, $urandom, $urandom, 1'b0, 1'b0);
            n++;
        end
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic mid_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_busy", {31'b0, busy}, 32'd0);
        check_eq("rst_hi", hi, 32'd0);
        check_eq("rst_lo", lo, 32'd0);
        m_hi       = '0;
        m_lo       = '0;
        pend       = 1'b0;
        busy_until = -1;
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int n;
        reset   = 1'b0;
        Req     = 1'b0;
        md_op   = 3'd0;
        rs_data = '0;
        rt_data = '0;
        rd_sel  = 1'b0;
        #12;
        check_eq("init_busy", {31'b0, busy}, 32'd0);
        check_eq("init_hi", hi, 32'd0);
        check_eq("init_lo", lo, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // mult -3 * 7
        cycle(3'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("mult_busy_len", n, MultCycles);
        check_eq("mult_hi", hi, 32'hFFFF_FFFF);
        check_eq("mult_lo", lo, 32'hFFFF_FFEB);
        rd_sel = 1'b1;
        #1;
        check_eq("mult_md_out", md_out, 32'hFFFF_FFEB);

        // multu 0xFFFFFFFF * 2
        cycle(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("multu_busy_len", n, MultCycles);
        check_eq("multu_hi", hi, 32'h0000_0001);
        check_eq("multu_lo", lo, 32'hFFFF_FFFE);

        // div -7 / 2
        cycle(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("div_busy_len", n, DivCycles);
        check_eq("div_lo", lo, 32'hFFFF_FFFD);
        check_eq("div_hi", hi, 32'hFFFF_FFFF);

        // mthi / mtlo, then divu by zero leaves HI/LO intact
        cycle(3'd5, 32'h1111_1111, 32'd0, 1'b0, 1'b0);
        check_eq("mthi", hi, 32'h1111_1111);
        cycle(3'd6, 32'h2222_2222, 32'd0, 1'b0, 1'b1);
        check_eq("mtlo", lo, 32'h2222_2222);
        cycle(3'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("divz_busy_len", n, DivCycles);
        check_eq("divz_hi", hi, 32'h1111_1111);
        check_eq("divz_lo", lo, 32'h2222_2222);

        // Req suppresses a mult issued in the same cycle
        cycle(3'd1, 32'd5, 32'd5, 1'b1, 1'b0);
        check_eq("req_busy", {31'b0, busy}, 32'd0);
        check_eq("req_hi", hi, 32'h1111_1111);
        check_eq("req_lo", lo, 32'h2222_2222);

        // mult issued while a div is busy is ignored
        cycle(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        cycle(3'd1, 32'd3, 32'd3, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("ovl_busy_len", n + 1, DivCycles);
        check_eq("ovl_lo", lo, 32'd14);
        check_eq("ovl_hi", hi, 32'd2);

        // Reset pulled at div cycle 4
        cycle(3'd3, 32'd100, 32'd7, 1'b0, 1'b0);
        cycle(3'd1, 32'd3, 32'd3, 1'b0, 1'b0);
        cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        mid_reset();
        cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'b0);
        check_eq("post_rst_busy", {31'b0, busy}, 32'd0);

        // Signed overflow case
        cycle(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_idle(n);
        check_eq("ovf_lo", lo, 32'h8000_0000);
        check_eq("ovf_hi", hi, 32'h0000_0000);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0) mid_reset();
            cycle(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
                  ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 12; i++) cycle(3'd0, 32'd0, 32'd0, 1'b0, 1'($urandom_range(0, 1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
